// File: rtl/per_fragment_test_lanes.sv
// per_fragment_test_lanes: multi-lane depth clamp, alpha/depth/stencil test, stencil op and write masking
// behind a three-stage elastic valid/ready pipeline, with fragment statistics counters.
module per_fragment_test_lanes #(
    parameter int NUM_LANES       = 2,
    parameter int DEPTH_WIDTH     = 16,
    parameter int STENCIL_WIDTH   = 4,
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int INDEX_WIDTH     = 14
) (
    input  logic                                     aclk,
    input  logic                                     reset,
    input  logic [2:0]                               conf_alpha_func,
    input  logic [2:0]                               conf_depth_func,
    input  logic [2:0]                               conf_stencil_func,
    input  logic [SUB_PIXEL_WIDTH-1:0]               conf_alpha_ref,
    input  logic [STENCIL_WIDTH-1:0]                 conf_stencil_ref,
    input  logic [STENCIL_WIDTH-1:0]                 conf_stencil_mask,
    input  logic [STENCIL_WIDTH-1:0]                 conf_stencil_write_mask,
    input  logic [2:0]                               conf_op_fail,
    input  logic [2:0]                               conf_op_zfail,
    input  logic [2:0]                               conf_op_zpass,
    input  logic [2:0]                               conf_enable,
    input  logic                                     conf_depth_write,
    input  logic [3:0]                               conf_color_mask,
    input  logic                                     s_tvalid,
    output logic                                     s_tready,
    input  logic                                     s_tlast,
    input  logic [NUM_LANES-1:0]                     s_tkeep,
    input  logic [NUM_LANES*4*SUB_PIXEL_WIDTH-1:0]   s_tcolor,
    input  logic [NUM_LANES*4*SUB_PIXEL_WIDTH-1:0]   s_tdest_color,
    input  logic [NUM_LANES*32-1:0]                  s_tdepth,
    input  logic [NUM_LANES*DEPTH_WIDTH-1:0]         s_tdest_depth,
    input  logic [NUM_LANES*STENCIL_WIDTH-1:0]       s_tdest_stencil,
    input  logic [NUM_LANES*INDEX_WIDTH-1:0]         s_tindex,
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic                                     m_tlast,
    output logic [NUM_LANES*INDEX_WIDTH-1:0]         m_taddr,
    output logic [NUM_LANES*4*SUB_PIXEL_WIDTH-1:0]   m_color_tdata,
    output logic [NUM_LANES*4-1:0]                   m_color_tstrb,
    output logic [NUM_LANES*DEPTH_WIDTH-1:0]         m_depth_tdata,
    output logic [NUM_LANES-1:0]                     m_depth_tstrb,
    output logic [NUM_LANES*STENCIL_WIDTH-1:0]       m_stencil_tdata,
    output logic [NUM_LANES-1:0]                     m_stencil_tstrb,
    output logic                                     idle,
    output logic [31:0]                              cnt_processed,
    output logic [31:0]                              cnt_passed
);
    localparam int NL  = NUM_LANES;
    localparam int DW  = DEPTH_WIDTH;
    localparam int SW  = STENCIL_WIDTH;
    localparam int PW  = SUB_PIXEL_WIDTH;
    localparam int IW  = INDEX_WIDTH;
    localparam int CPW = 4 * PW;
    localparam int MW  = DW > PW ? DW : PW;
    localparam int CW  = MW > SW ? MW : SW;

    function automatic logic f_test(input logic [2:0] fn, input logic [CW-1:0] a, input logic [CW-1:0] b);
        case (fn)
            3'd1:    f_test = a < b;
            3'd2:    f_test = a == b;
            3'd3:    f_test = a <= b;
            3'd4:    f_test = a > b;
            3'd5:    f_test = a != b;
            3'd6:    f_test = a >= b;
            3'd7:    f_test = 1'b1;
            default: f_test = 1'b0;
        endcase
    endfunction

    function automatic logic [SW-1:0] f_op(input logic [2:0] op, input logic [SW-1:0] s, input logic [SW-1:0] r);
        case (op)
            3'd1:    f_op = '0;
            3'd2:    f_op = r;
            3'd3:    f_op = (&s) ? s : s + 1'b1;
            3'd4:    f_op = (|s) ? s - 1'b1 : s;
            3'd5:    f_op = ~s;
            3'd6:    f_op = s + 1'b1;
            3'd7:    f_op = s - 1'b1;
            default: f_op = s;
        endcase
    endfunction

    function automatic logic [31:0] f_pop(input logic [NL-1:0] v);
        f_pop = '0;
        for (int i = 0; i < NL; i++) f_pop = f_pop + 32'(v[i]);
    endfunction

    logic [NL-1:0][CPW-1:0] w_color;
    logic [NL-1:0][31:0]    w_depth;
    logic [NL-1:0][DW-1:0]  w_ddepth;
    logic [NL-1:0][SW-1:0]  w_dsten;
    logic [NL-1:0][IW-1:0]  w_index;
    logic                   w_unused;
    assign w_color  = s_tcolor;
    assign w_depth  = s_tdepth;
    assign w_ddepth = s_tdest_depth;
    assign w_dsten  = s_tdest_stencil;
    assign w_index  = s_tindex;
    // Destination colour is already resolved by the blend stage; it is accepted but not needed here.
    assign w_unused = ^s_tdest_color;

    logic                   r1_v, r1_last;
    logic [NL-1:0]          r1_keep, r1_apass, r1_zpass, r1_spass;
    logic [NL-1:0][CPW-1:0] r1_color;
    logic [NL-1:0][IW-1:0]  r1_index;
    logic [NL-1:0][DW-1:0]  r1_depth;
    logic [NL-1:0][SW-1:0]  r1_dsten;

    logic                   r2_v, r2_last;
    logic [NL-1:0]          r2_keep, r2_pass;
    logic [NL-1:0][CPW-1:0] r2_color;
    logic [NL-1:0][IW-1:0]  r2_index;
    logic [NL-1:0][DW-1:0]  r2_depth;
    logic [NL-1:0][SW-1:0]  r2_sten;

    logic                   r3_v, r3_last;
    logic [NL-1:0]          r3_keep, r3_pass, r3_zstrb, r3_sstrb;
    logic [NL-1:0][3:0]     r3_cstrb;
    logic [NL-1:0][CPW-1:0] r3_color;
    logic [NL-1:0][IW-1:0]  r3_index;
    logic [NL-1:0][DW-1:0]  r3_depth;
    logic [NL-1:0][SW-1:0]  r3_sten;
    logic [31:0]            r_cnt_proc, r_cnt_pass;

    logic w_ld1, w_ld2, w_ld3;
    assign w_ld3    = !r3_v || m_tready;
    assign w_ld2    = !r2_v || w_ld3;
    assign w_ld1    = !r1_v || w_ld2;
    assign s_tready = w_ld1;

    logic [NL-1:0][DW-1:0] w1_depth;
    logic [NL-1:0]         w1_apass, w1_zpass, w1_spass;
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            w1_depth[k] = w_depth[k][31] ? '0 : (|w_depth[k][31:32-DW]) ? '1 : w_depth[k][DW-1:0];
            w1_apass[k] = !conf_enable[0] || f_test(conf_alpha_func, CW'(w_color[k][PW-1:0]), CW'(conf_alpha_ref));
            w1_zpass[k] = !conf_enable[1] || f_test(conf_depth_func, CW'(w1_depth[k]), CW'(w_ddepth[k]));
            w1_spass[k] = !conf_enable[2] || f_test(conf_stencil_func, CW'(conf_stencil_ref & conf_stencil_mask),
                                                    CW'(w_dsten[k] & conf_stencil_mask));
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r1_v     <= 1'b0;
            r1_last  <= 1'b0;
            r1_keep  <= '0;
            r1_apass <= '0;
            r1_zpass <= '0;
            r1_spass <= '0;
            r1_color <= '0;
            r1_index <= '0;
            r1_depth <= '0;
            r1_dsten <= '0;
        end else if (w_ld1) begin
            r1_v <= s_tvalid;
            if (s_tvalid) begin
                r1_last  <= s_tlast;
                r1_keep  <= s_tkeep;
                r1_apass <= w1_apass;
                r1_zpass <= w1_zpass;
                r1_spass <= w1_spass;
                r1_color <= w_color;
                r1_index <= w_index;
                r1_depth <= w1_depth;
                r1_dsten <= w_dsten;
            end
        end
    end

    logic [NL-1:0][2:0]    w2_op;
    logic [NL-1:0][SW-1:0] w2_sten;
    logic [NL-1:0]         w2_pass;
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            w2_op[k]   = !r1_spass[k] ? conf_op_fail : !r1_zpass[k] ? conf_op_zfail : conf_op_zpass;
            w2_sten[k] = (f_op(w2_op[k], r1_dsten[k], conf_stencil_ref) & conf_stencil_write_mask)
                       | (r1_dsten[k] & ~conf_stencil_write_mask);
            w2_pass[k] = r1_apass[k] & r1_zpass[k] & r1_spass[k];
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r2_v     <= 1'b0;
            r2_last  <= 1'b0;
            r2_keep  <= '0;
            r2_pass  <= '0;
            r2_color <= '0;
            r2_index <= '0;
            r2_depth <= '0;
            r2_sten  <= '0;
        end else if (w_ld2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_last  <= r1_last;
                r2_keep  <= r1_keep;
                r2_pass  <= w2_pass;
                r2_color <= r1_color;
                r2_index <= r1_index;
                r2_depth <= r1_depth;
                r2_sten  <= w2_sten;
            end
        end
    end

    logic [NL-1:0][3:0] w3_cstrb;
    logic [NL-1:0]      w3_zstrb, w3_sstrb;
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            w3_cstrb[k] = (r2_keep[k] && r2_pass[k]) ? conf_color_mask : 4'b0;
            w3_zstrb[k] = r2_keep[k] & r2_pass[k] & conf_enable[1] & conf_depth_write;
            w3_sstrb[k] = r2_keep[k] & conf_enable[2] & (|conf_stencil_write_mask);
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r3_v     <= 1'b0;
            r3_last  <= 1'b0;
            r3_keep  <= '0;
            r3_pass  <= '0;
            r3_cstrb <= '0;
            r3_zstrb <= '0;
            r3_sstrb <= '0;
            r3_color <= '0;
            r3_index <= '0;
            r3_depth <= '0;
            r3_sten  <= '0;
        end else if (w_ld3) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_last  <= r2_last;
                r3_keep  <= r2_keep;
                r3_pass  <= r2_pass;
                r3_cstrb <= w3_cstrb;
                r3_zstrb <= w3_zstrb;
                r3_sstrb <= w3_sstrb;
                r3_color <= r2_color;
                r3_index <= r2_index;
                r3_depth <= r2_depth;
                r3_sten  <= r2_sten;
            end
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_cnt_proc <= '0;
            r_cnt_pass <= '0;
        end else if (r3_v && m_tready) begin
            r_cnt_proc <= r_cnt_proc + f_pop(r3_keep);
            r_cnt_pass <= r_cnt_pass + f_pop(r3_keep & r3_pass);
        end
    end

    assign m_tvalid        = r3_v;
    assign m_tlast         = r3_last;
    assign m_taddr         = r3_index;
    assign m_color_tdata   = r3_color;
    assign m_color_tstrb   = r3_cstrb;
    assign m_depth_tdata   = r3_depth;
    assign m_depth_tstrb   = r3_zstrb;
    assign m_stencil_tdata = r3_sten;
    assign m_stencil_tstrb = r3_sstrb;
    assign idle            = !(r1_v || r2_v || r3_v);
    assign cnt_processed   = r_cnt_proc;
    assign cnt_passed      = r_cnt_pass;
endmodule

// File: tb/tb_per_fragment_test_lanes.sv
// tb_per_fragment_test_lanes: directed vector table plus stall and mid-stream reset sequences.
module tb_per_fragment_test_lanes;
    logic        aclk = 1'b0;
    logic        reset;
    logic [2:0]  conf_alpha_func, conf_depth_func, conf_stencil_func;
    logic [7:0]  conf_alpha_ref;
    logic [3:0]  conf_stencil_ref, conf_stencil_mask, conf_stencil_write_mask;
    logic [2:0]  conf_op_fail, conf_op_zfail, conf_op_zpass, conf_enable;
    logic        conf_depth_write;
    logic [3:0]  conf_color_mask;
    logic        s_tvalid, s_tready, s_tlast;
    logic [1:0]  s_tkeep;
    logic [63:0] s_tcolor, s_tdest_color, s_tdepth;
    logic [31:0] s_tdest_depth;
    logic [7:0]  s_tdest_stencil;
    logic [27:0] s_tindex;
    logic        m_tvalid, m_tready, m_tlast;
    logic [27:0] m_taddr;
    logic [63:0] m_color_tdata;
    logic [7:0]  m_color_tstrb;
    logic [31:0] m_depth_tdata;
    logic [1:0]  m_depth_tstrb;
    logic [7:0]  m_stencil_tdata;
    logic [1:0]  m_stencil_tstrb;
    logic        idle;
    logic [31:0] cnt_processed, cnt_passed;

    per_fragment_test_lanes dut (
        .aclk(aclk), .reset(reset),
        .conf_alpha_func(conf_alpha_func), .conf_depth_func(conf_depth_func), .conf_stencil_func(conf_stencil_func),
        .conf_alpha_ref(conf_alpha_ref), .conf_stencil_ref(conf_stencil_ref), .conf_stencil_mask(conf_stencil_mask),
        .conf_stencil_write_mask(conf_stencil_write_mask), .conf_op_fail(conf_op_fail), .conf_op_zfail(conf_op_zfail),
        .conf_op_zpass(conf_op_zpass), .conf_enable(conf_enable), .conf_depth_write(conf_depth_write),
        .conf_color_mask(conf_color_mask),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .s_tcolor(s_tcolor), .s_tdest_color(s_tdest_color), .s_tdepth(s_tdepth),
        .s_tdest_depth(s_tdest_depth), .s_tdest_stencil(s_tdest_stencil), .s_tindex(s_tindex),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_taddr(m_taddr),
        .m_color_tdata(m_color_tdata), .m_color_tstrb(m_color_tstrb),
        .m_depth_tdata(m_depth_tdata), .m_depth_tstrb(m_depth_tstrb),
        .m_stencil_tdata(m_stencil_tdata), .m_stencil_tstrb(m_stencil_tstrb),
        .idle(idle), .cnt_processed(cnt_processed), .cnt_passed(cnt_passed)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0]  en, afn, zfn, sfn;
        logic [7:0]  aref;
        logic [3:0]  sref, smask, swm;
        logic [2:0]  opf, opzf, opzp;
        logic        zw;
        logic [3:0]  cmask;
        logic [1:0]  keep;
        logic [63:0] color, depth;
        logic [31:0] ddepth;
        logic [7:0]  dsten;
        logic [31:0] x_depth;
        logic [7:0]  x_sten, x_cstrb;
        logic [1:0]  x_zstrb, x_sstrb;
        logic [31:0] x_pass;
    } vec_t;

    localparam logic [63:0] C0 = 64'h11223344_55667788;
    localparam logic [63:0] C1 = 64'hAABBCC80_AABBCC90;

    vec_t        vecs[11];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_proc = 0;
    logic [31:0] exp_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        conf_enable = v.en; conf_alpha_func = v.afn; conf_depth_func = v.zfn; conf_stencil_func = v.sfn;
        conf_alpha_ref = v.aref; conf_stencil_ref = v.sref; conf_stencil_mask = v.smask;
        conf_stencil_write_mask = v.swm; conf_op_fail = v.opf; conf_op_zfail = v.opzf; conf_op_zpass = v.opzp;
        conf_depth_write = v.zw; conf_color_mask = v.cmask;
        s_tkeep = v.keep; s_tcolor = v.color; s_tdest_color = ~v.color; s_tdepth = v.depth;
        s_tdest_depth = v.ddepth; s_tdest_stencil = v.dsten;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [27:0] idx;
        logic [63:0] cm;
        logic [31:0] zm;
        logic [7:0]  sm;
        logic [27:0] am;
        v   = vecs[i];
        idx = {14'(50 + i), 14'(10 + i)};
        cm  = {{32{v.keep[1]}}, {32{v.keep[0]}}};
        zm  = {{16{v.keep[1]}}, {16{v.keep[0]}}};
        sm  = {{4{v.keep[1]}}, {4{v.keep[0]}}};
        am  = {{14{v.keep[1]}}, {14{v.keep[0]}}};
        @(negedge aclk);
        set_cfg(v);
        s_tindex = idx; s_tlast = (i % 2 == 1); s_tvalid = 1'b1; m_tready = 1'b1;
        #1 chk($sformatf("v%0d s_tready", i), s_tready, 1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        chk($sformatf("v%0d latency1", i), m_tvalid, 0);
        @(negedge aclk);
        chk($sformatf("v%0d latency2", i), m_tvalid, 0);
        @(negedge aclk);
        chk($sformatf("v%0d m_tvalid", i), m_tvalid, 1);
        chk($sformatf("v%0d m_tlast", i), m_tlast, (i % 2 == 1));
        chk($sformatf("v%0d m_taddr", i), m_taddr & am, idx & am);
        chk($sformatf("v%0d color", i), m_color_tdata & cm, v.color & cm);
        chk($sformatf("v%0d depth", i), m_depth_tdata & zm, v.x_depth & zm);
        chk($sformatf("v%0d stencil", i), m_stencil_tdata & sm, v.x_sten & sm);
        chk($sformatf("v%0d color_tstrb", i), m_color_tstrb, v.x_cstrb);
        chk($sformatf("v%0d depth_tstrb", i), m_depth_tstrb, v.x_zstrb);
        chk($sformatf("v%0d stencil_tstrb", i), m_stencil_tstrb, v.x_sstrb);
        exp_proc = exp_proc + $countones(v.keep);
        exp_pass = exp_pass + v.x_pass;
        @(negedge aclk);
        chk($sformatf("v%0d cnt_processed", i), cnt_processed, exp_proc);
        chk($sformatf("v%0d cnt_passed", i), cnt_passed, exp_pass);
        chk($sformatf("v%0d idle", i), idle, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          sent, got;
        logic [27:0] got_addr[4];
        logic        got_last[4];
        // en afn zfn sfn aref sref smask swm opf opzf opzp zw cmask keep color depth ddepth dsten | x_depth x_sten x_cstrb x_zstrb x_sstrb x_pass
        vecs[0]  = '{3'b010, 3'd7, 3'd1, 3'd7, 8'h00, 4'h0, 4'hF, 4'hF, 3'd0, 3'd0, 3'd0, 1'b1, 4'hF, 2'b11, C0, 64'hC0000000_00004000, 32'h8000_8000, 8'h21, 32'h0000_4000, 8'h21, 8'hFF, 2'b11, 2'b00, 32'd2};
        vecs[1]  = '{3'b010, 3'd7, 3'd1, 3'd7, 8'h00, 4'h0, 4'hF, 4'hF, 3'd0, 3'd0, 3'd0, 1'b1, 4'hF, 2'b11, C0, 64'h00010000_00010000, 32'h8000_8000, 8'h21, 32'hFFFF_FFFF, 8'h21, 8'h00, 2'b00, 2'b00, 32'd0};
        vecs[2]  = '{3'b100, 3'd7, 3'd7, 3'd2, 8'h00, 4'h3, 4'hF, 4'hF, 3'd1, 3'd0, 3'd3, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h23, 32'h0, 8'h04, 8'h0F, 2'b00, 2'b11, 32'd1};
        vecs[3]  = '{3'b100, 3'd7, 3'd7, 3'd2, 8'h00, 4'hF, 4'hF, 4'hF, 3'd1, 3'd0, 3'd3, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'hFF, 32'h0, 8'hFF, 8'hFF, 2'b00, 2'b11, 32'd2};
        vecs[4]  = '{3'b000, 3'd7, 3'd7, 3'd7, 8'h00, 4'h0, 4'hF, 4'hF, 3'd0, 3'd0, 3'd0, 1'b1, 4'b1010, 2'b01, C0, 64'h00005678_00001234, 32'h0, 8'h5A, 32'h5678_1234, 8'h5A, 8'h0A, 2'b00, 2'b00, 32'd1};
        vecs[5]  = '{3'b001, 3'd4, 3'd7, 3'd7, 8'h80, 4'h0, 4'hF, 4'hF, 3'd0, 3'd0, 3'd0, 1'b1, 4'hF, 2'b11, C1, 64'h0, 32'h0, 8'h00, 32'h0, 8'h00, 8'h0F, 2'b00, 2'b00, 32'd1};
        vecs[6]  = '{3'b100, 3'd7, 3'd7, 3'd7, 8'h00, 4'h0, 4'hF, 4'h3, 3'd0, 3'd0, 3'd5, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h50, 32'h0, 8'h63, 8'hFF, 2'b00, 2'b11, 32'd2};
        vecs[7]  = '{3'b110, 3'd7, 3'd0, 3'd7, 8'h00, 4'h9, 4'hF, 4'hF, 3'd0, 3'd2, 3'd0, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h00, 32'h0, 8'h99, 8'h00, 2'b00, 2'b11, 32'd0};
        vecs[8]  = '{3'b100, 3'd7, 3'd7, 3'd7, 8'h00, 4'h0, 4'hF, 4'hF, 3'd0, 3'd0, 3'd6, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h7F, 32'h0, 8'h80, 8'hFF, 2'b00, 2'b11, 32'd2};
        vecs[9]  = '{3'b100, 3'd7, 3'd7, 3'd1, 8'h00, 4'h2, 4'h3, 4'hF, 3'd7, 3'd0, 3'd4, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h36, 32'h0, 8'h25, 8'hF0, 2'b00, 2'b11, 32'd1};
        vecs[10] = '{3'b100, 3'd7, 3'd7, 3'd7, 8'h00, 4'h0, 4'hF, 4'h0, 3'd0, 3'd0, 3'd1, 1'b1, 4'hF, 2'b11, C0, 64'h0, 32'h0, 8'h5A, 32'h0, 8'h5A, 8'hFF, 2'b00, 2'b00, 32'd2};

        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tindex = '0; m_tready = 1'b1;
        set_cfg(vecs[0]);
        #12;
        chk("reset m_tvalid", m_tvalid, 0);
        chk("reset idle", idle, 1);
        chk("reset cnt_processed", cnt_processed, 0);
        chk("reset color_tstrb", m_color_tstrb, 0);
        chk("reset m_taddr", m_taddr, 0);
        #10 reset = 1'b0;
        #1 chk("post-reset s_tready", s_tready, 1);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Back-pressure: five stalled cycles while four beats are offered.
        set_cfg(vecs[10]);
        sent = 0; got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge aclk);
            m_tready = (c >= 5);
            s_tvalid = (sent < 4);
            s_tindex = {14'(200 + sent), 14'(100 + sent)};
            s_tlast  = (sent == 3);
            #1;
            if (c == 3 || c == 4) begin
                chk($sformatf("stall c%0d s_tready", c), s_tready, 0);
                chk($sformatf("stall c%0d m_tvalid", c), m_tvalid, 1);
                chk($sformatf("stall c%0d m_taddr", c), m_taddr, {14'd200, 14'd100});
                chk($sformatf("stall c%0d m_tlast", c), m_tlast, 0);
            end
            if (m_tvalid && m_tready) begin
                got_addr[got] = m_taddr;
                got_last[got] = m_tlast;
                got++;
            end
            if (s_tvalid && s_tready) sent++;
            if (c == 4) chk("stall beats accepted", sent, 3);
        end
        chk("stall beats received", got, 4);
        for (int j = 0; j < got; j++) begin
            chk($sformatf("stall order %0d", j), got_addr[j], {14'(200 + j), 14'(100 + j)});
            chk($sformatf("stall tlast %0d", j), got_last[j], (j == 3));
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        exp_proc = exp_proc + 8;
        exp_pass = exp_pass + 8;
        @(negedge aclk);
        chk("stall cnt_processed", cnt_processed, exp_proc);
        chk("stall cnt_passed", cnt_passed, exp_pass);
        chk("stall idle", idle, 1);

        // Asynchronous reset with two beats in flight.
        m_tready = 1'b0;
        @(negedge aclk);
        s_tvalid = 1'b1; s_tindex = 28'h0AAAAAA;
        @(negedge aclk);
        s_tindex = 28'h0555555;
        @(negedge aclk);
        s_tvalid = 1'b0;
        @(negedge aclk);
        chk("pre-reset m_tvalid", m_tvalid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset m_tvalid", m_tvalid, 0);
        chk("async reset idle", idle, 1);
        chk("async reset cnt_processed", cnt_processed, 0);
        chk("async reset cnt_passed", cnt_passed, 0);
        chk("async reset stencil_tstrb", m_stencil_tstrb, 0);
        chk("async reset m_taddr", m_taddr, 0);
        @(negedge aclk);
        reset = 1'b0;
        #1 chk("after reset s_tready", s_tready, 1);
        exp_proc = 0;
        exp_pass = 0;
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
